// File: rtl/vga_fb_pkg.sv
// Shared types, widths and helpers for the VGA framebuffer reader.
package vga_fb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned BC_W   = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} fb_state_t;

  function automatic int unsigned frame_words(input int unsigned hdisp,
                                              input int unsigned vdisp);
    return hdisp * vdisp;
  endfunction

  // Byte address of a 32-bit pixel word.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] base,
                                                input logic [ADDR_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// Avalon-MM burst bus between a host and an agent (SDRAM arbiter port).
interface avalon_if;
  import vga_fb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [BC_W-1:0]   burstcount;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport host (
    output address, read, write, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport agent (
    input  address, read, write, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/vga_fb_reader.sv
// Streams the framebuffer from SDRAM into the VGA pixel FIFO using fixed-length
// Avalon read bursts in raster order, one burst outstanding at a time.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int unsigned       HDISP     = 800,
  parameter int unsigned       VDISP     = 480,
  parameter int unsigned       BURSTSIZE = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  avalon_if.host            avalon_ifh_sdram,
  input  logic              enable,
  input  logic              frame_restart,
  input  logic              wfifo_almost_full,
  output logic [DATA_W-1:0] wfifo_data,
  output logic              wfifo_write,
  output logic              busy
);

  localparam int unsigned FRAME_WORDS = frame_words(HDISP, VDISP);
  localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);
  localparam int unsigned SUM_W       = IDX_W + 1;
  localparam int unsigned BEAT_W      = $clog2(BURSTSIZE + 1);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_REQ  = 2'(REQ);
  localparam logic [1:0] S_WAIT = 2'(WAIT_DATA);

  logic [1:0]        state_q, state_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [BC_W-1:0]   burstcount_q;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic [SUM_W-1:0]  idx_sum;
  logic [IDX_W-1:0]  idx_next;

  assign avalon_ifh_sdram.read       = read_q;
  assign avalon_ifh_sdram.address    = address_q;
  assign avalon_ifh_sdram.burstcount = burstcount_q;
  assign avalon_ifh_sdram.write      = 1'b0;
  assign avalon_ifh_sdram.byteenable = '1;
  assign wfifo_write = wr_q;
  assign wfifo_data  = data_q;
  assign busy        = busy_q;

  // Next burst start, wrapping exactly at end of frame.
  assign idx_sum  = SUM_W'(idx_q) + SUM_W'(BURSTSIZE);
  assign idx_next = (idx_sum == SUM_W'(FRAME_WORDS)) ? '0 : idx_sum[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    address_d = address_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    pend_d    = pend_q | frame_restart;
    busy_d    = busy_q;

    // Beats seen in IDLE are stale leftovers of a burst cut off by reset.
    if ((state_q == S_REQ || state_q == S_WAIT) && avalon_ifh_sdram.readdatavalid) begin
      wr_d   = 1'b1;
      data_d = avalon_ifh_sdram.readdata;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = frame_restart;
          idx_d  = '0;
        end else if (enable && !wfifo_almost_full) begin
          state_d   = S_REQ;
          read_d    = 1'b1;
          address_d = fb_addr(BASE_ADDR, ADDR_W'(idx_q));
          busy_d    = 1'b1;
        end
      end
      S_REQ: begin
        if (read_q && !avalon_ifh_sdram.waitrequest) begin
          state_d = S_WAIT;
          read_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (avalon_ifh_sdram.readdatavalid) begin
          if (beat_q == BEAT_W'(BURSTSIZE - 1)) begin
            beat_d  = '0;
            idx_d   = idx_next;
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      address_q    <= BASE_ADDR;
      burstcount_q <= BC_W'(BURSTSIZE);
      wr_q         <= 1'b0;
      data_q       <= '0;
      idx_q        <= '0;
      beat_q       <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      address_q    <= address_d;
      burstcount_q <= BC_W'(BURSTSIZE);
      wr_q         <= wr_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      beat_q       <= beat_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed/randomised bench for vga_fb_reader with an Avalon agent model and
// a pixel-index reference model of the raster walk.
module tb_vga_fb_reader;
  import vga_fb_pkg::*;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned BS = 16;
  localparam int unsigned FW = H * V;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk;
  logic        rst, rst_main, rst_resp;
  logic        frame_restart, rs_main, rs_resp;
  logic        enable, af;
  logic [31:0] wfifo_data;
  logic        wfifo_write, busy;

  assign rst           = rst_main | rst_resp;
  assign frame_restart = rs_main | rs_resp;

  avalon_if bus();

  vga_fb_reader #(.HDISP(H), .VDISP(V), .BURSTSIZE(BS), .BASE_ADDR(BASE)) dut (
    .clk               (clk),
    .rst               (rst),
    .avalon_ifh_sdram  (bus),
    .enable            (enable),
    .frame_restart     (frame_restart),
    .wfifo_almost_full (af),
    .wfifo_data        (wfifo_data),
    .wfifo_write       (wfifo_write),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_bc[$];
  logic [31:0] sent[$];
  logic [31:0] wrote[$];
  int lat_err = 0, stable_err = 0;
  int lat = 3;
  bit gap_en = 0;
  int rst_beat = -1;
  bit restart_last = 0;
  int m_idx = 0;
  bit m_pend = 0;
  int acc_i = 0, wr_idx = 0, sn_idx = 0;

  // Avalon agent: records each accepted command and returns BS beats whose
  // low half is the pixel index and high half is random.
  initial begin : responder
    logic [31:0] a;
    int g;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    rst_resp = 1'b0;
    rs_resp  = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.read === 1'b1 && bus.waitrequest === 1'b0) begin
        a = bus.address;
        acc_addr.push_back(a);
        acc_bc.push_back(32'(bus.burstcount));
        repeat (lat - 1) @(negedge clk);
        for (int b = 0; b < int'(BS); b++) begin
          g = gap_en ? int'($urandom_range(0, 2)) : 0;
          repeat (g) begin
            @(negedge clk);
            bus.readdatavalid = 1'b0; rst_resp = 1'b0; rs_resp = 1'b0;
          end
          @(negedge clk);
          rst_resp = 1'b0; rs_resp = 1'b0;
          bus.readdatavalid = 1'b1;
          bus.readdata = {16'($urandom), 16'((a >> 2) + 32'(b))};
          sent.push_back(bus.readdata);
          if (b == rst_beat) rst_resp = 1'b1;
          if (b == int'(BS) - 1 && restart_last) rs_resp = 1'b1;
        end
        @(negedge clk);
        bus.readdatavalid = 1'b0; rst_resp = 1'b0; rs_resp = 1'b0;
      end
    end
  end

  // Records FIFO writes, their one-cycle latency, and command stability under waitrequest.
  initial begin : monitor
    logic p_rdv, p_hold, p_rst;
    logic [31:0] p_rd, p_addr;
    logic [BC_W-1:0] p_bc;
    p_rdv = 0; p_hold = 0; p_rst = 1; p_rd = 0; p_addr = 0; p_bc = 0;
    forever begin
      @(posedge clk);
      if (wfifo_write === 1'b1) begin
        wrote.push_back(wfifo_data);
        if (!(p_rdv === 1'b1 && p_rd === wfifo_data)) lat_err++;
      end
      if (p_hold && !p_rst &&
          !(bus.read === 1'b1 && bus.address === p_addr && bus.burstcount === p_bc))
        stable_err++;
      p_rdv  = bus.readdatavalid;
      p_rd   = bus.readdata;
      p_rst  = rst;
      p_hold = (bus.read === 1'b1 && bus.waitrequest === 1'b1);
      p_addr = bus.address;
      p_bc   = bus.burstcount;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input string tag);
    bit ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = (acc_addr.size() > acc_i);
    end
    chk({tag, " accepted"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, " address"}, acc_addr[acc_i], BASE + 32'(m_idx * 4));
      chk({tag, " burstcount"}, acc_bc[acc_i], 32'(BS));
      acc_i++;
    end
  endtask

  task automatic wait_data(input string tag);
    bit ok = 0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      ok = (wrote.size() >= wr_idx + int'(BS));
    end
    chk({tag, " beats"}, 32'(ok), 32'd1);
    if (ok) begin
      for (int b = 0; b < int'(BS); b++) begin
        chk({tag, " data"}, wrote[wr_idx + b], sent[sn_idx + b]);
        chk({tag, " pixel"}, 32'(wrote[wr_idx + b][15:0]), 32'((m_idx + b) % 65536));
      end
    end
    wr_idx += int'(BS);
    sn_idx += int'(BS);
    m_idx = (m_idx + int'(BS)) % int'(FW);
    if (m_pend) begin
      m_idx  = 0;
      m_pend = 0;
    end
  endtask

  initial begin : stim
    int w0;
    bit ok;
    rst_main = 1'b1; rs_main = 1'b0; enable = 1'b0; af = 1'b0;
    bus.waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst read", 32'(bus.read), 32'd0);
    chk("rst address", bus.address, BASE);
    chk("rst burstcount", 32'(bus.burstcount), 32'(BS));
    chk("rst wfifo_write", 32'(wfifo_write), 32'd0);
    chk("rst wfifo_data", wfifo_data, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("const write", 32'(bus.write), 32'd0);
    chk("const byteenable", 32'(bus.byteenable), 32'hf);
    rst_main = 1'b0;
    repeat (2) @(negedge clk);
    chk("disabled read", 32'(bus.read), 32'd0);

    // First two bursts, fixed 3-cycle latency.
    lat = 3; gap_en = 0; enable = 1'b1;
    wait_acc("b0"); wait_data("b0");
    wait_acc("b1"); wait_data("b1");
    chk("latency", 32'(lat_err), 32'd0);

    // Full-frame wrap with random latency, beat gaps and command stalls.
    gap_en = 1;
    w0 = wrote.size();
    for (int i = 0; i < 4; i++) begin
      lat = int'($urandom_range(1, 6));
      bus.waitrequest = 1'b1;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      bus.waitrequest = 1'b0;
      wait_acc("frame");
      if (i == 3) enable = 1'b0;
      wait_data("frame");
      if (i == 1) chk("frame writes", 32'(wrote.size() - w0), 32'(FW));
    end

    // Long waitrequest stall.
    repeat (3) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    bus.waitrequest = 1'b1; enable = 1'b1;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = (bus.read === 1'b1);
    end
    chk("stall read seen", 32'(ok), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("stall read", 32'(bus.read), 32'd1);
      chk("stall address", bus.address, BASE + 32'(m_idx * 4));
      chk("stall burstcount", 32'(bus.burstcount), 32'(BS));
      @(negedge clk);
    end
    chk("stall no accept", 32'(acc_addr.size()), 32'(acc_i));
    bus.waitrequest = 1'b0;
    @(negedge clk);
    chk("stall read drop", 32'(bus.read), 32'd0);
    chk("stall one accept", 32'(acc_addr.size()), 32'(acc_i + 1));
    wait_acc("stall");
    enable = 1'b0;
    wait_data("stall");
    repeat (5) @(negedge clk);
    chk("stall single", 32'(acc_addr.size()), 32'(acc_i));
    chk("stall stable", 32'(stable_err), 32'd0);

    // Back-pressure raised mid-burst.
    enable = 1'b1; lat = 4;
    wait_acc("af");
    af = 1'b1;
    wait_data("af");
    repeat (20) @(negedge clk);
    chk("af hold", 32'(acc_addr.size()), 32'(acc_i));
    chk("af read", 32'(bus.read), 32'd0);
    chk("af busy", 32'(busy), 32'd0);
    af = 1'b0;
    wait_acc("af resume"); wait_data("af resume");

    // Frame restarts: mid-burst at 0x40, mid-burst at 0x0, and on the final beat.
    for (int i = 0; i < 2 && m_idx != 16; i++) begin
      wait_acc("align"); wait_data("align");
    end
    for (int i = 0; i < 2; i++) begin
      wait_acc("restart");
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge clk);
        ok = (wrote.size() >= wr_idx + 5);
      end
      rs_main = 1'b1; m_pend = 1;
      @(negedge clk);
      rs_main = 1'b0;
      wait_data("restart");
    end
    wait_acc("restart last");
    restart_last = 1; m_pend = 1;
    wait_data("restart last");
    restart_last = 0;
    wait_acc("after restart"); wait_data("after restart");
    wait_acc("after restart2"); wait_data("after restart2");

    // Reset mid-burst followed by stray beats.
    wait_acc("reset");
    enable = 1'b0; gap_en = 0; rst_beat = 7;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = (sent.size() >= sn_idx + int'(BS));
    end
    repeat (5) @(negedge clk);
    chk("reset stray writes", 32'(wrote.size()), 32'(wr_idx + 7));
    for (int b = 0; b < 7; b++) chk("reset data", wrote[wr_idx + b], sent[sn_idx + b]);
    chk("reset read", 32'(bus.read), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset address", bus.address, BASE);
    rst_beat = -1;
    wr_idx = wrote.size(); sn_idx = sent.size();
    m_idx = 0; m_pend = 0;
    enable = 1'b1; gap_en = 1;
    wait_acc("post reset"); wait_data("post reset");
    chk("final latency", 32'(lat_err), 32'd0);
    chk("final stable", 32'(stable_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Avalon-MM burst-read host that streams the framebuffer from SDRAM into the VGA pixel FIFO.
- Issues fixed-length read bursts in raster order, wraps at end of frame and honours FIFO back-pressure.
- Restarts at pixel 0 on a frame-sync request.
- Sits between the VGA controller's write-side FIFO and the VGA agent port of the SDRAM arbiter.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BURSTSIZE, 16, words per read burst; HDISP*VDISP must be a multiple of BURSTSIZE.
- BASE_ADDR, 32'h0, byte address of pixel 0.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high, sampled on the rising edge of clk
- avalon_ifh_sdram  avalon_if.host  -  uses address, read, burstcount, waitrequest, readdata(32), readdatavalid; write=0 and byteenable='1 constant
- enable  input  1  1 = fetching allowed
- frame_restart  input  1  single-cycle pulse: next burst starts at pixel 0
- wfifo_almost_full  input  1  0 guarantees at least BURSTSIZE free FIFO entries
- wfifo_data  output  32  pixel word to FIFO
- wfifo_write  output  1  FIFO write strobe
- busy  output  1  1 while a burst is outstanding (REQ or WAIT_DATA)

Behaviour:
- Reset values: state=IDLE, read=0, address=BASE_ADDR, burstcount=BURSTSIZE, wfifo_write=0, wfifo_data=0, pixel_idx=0, beat_cnt=0, restart_pend=0, busy=0.
- pixel_idx range is 0..HDISP*VDISP-1, width $clog2(HDISP*VDISP). address = BASE_ADDR + 4*pixel_idx (byte addressing).
- States:
  - IDLE: if restart_pend, clear it and load pixel_idx=0 (no request that cycle). Else if enable && !wfifo_almost_full, go to REQ.
  - REQ: read=1 with address and burstcount=BURSTSIZE. All three are held stable while waitrequest=1. On a cycle with read && !waitrequest, the command is accepted; next cycle read=0 and state goes to WAIT_DATA.
  - WAIT_DATA: each readdatavalid increments beat_cnt. When beat BURSTSIZE arrives, clear beat_cnt, set pixel_idx += BURSTSIZE (wrap to 0 when the result equals HDISP*VDISP) and return to IDLE.
- Data path:
  - On each readdatavalid in REQ or WAIT_DATA, wfifo_data <= readdata and wfifo_write <= 1, one-cycle latency; otherwise wfifo_write <= 0.
  - readdatavalid in IDLE is ignored: no FIFO write, no count. These are stale beats after a reset.
- Back-pressure: wfifo_almost_full is sampled only in IDLE. A burst in flight always completes.
- frame_restart:
  - A pulse in any state sets restart_pend; it is applied at the next IDLE.
  - A pulse coinciding with the final beat still causes the restart. The wrap/increment happens first, then pixel_idx=0 in IDLE.
- enable deasserted mid-burst: the burst completes, then the block stays in IDLE.
- Reset mid-burst: immediate return to reset values; read drops on the next edge.
- Read latency is arbitrary. waitrequest may be high for any number of cycles, including indefinitely (arbiter serving the stream writer).
- At most one burst is outstanding; no pipelined commands.

Decomposition:
- Package vga_fb_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} fb_state_t;
  - localparam FRAME_WORDS = HDISP*VDISP (as function of parameters);
  - function fb_addr(base, idx) returning base + (idx<<2).
- No sub-module; a single always_ff FSM with datapath counters.

Test Plan:
- Reset, enable=1, almost_full=0, waitrequest=0, readdatavalid 3 cycles after accept with readdata=idx -> first request address=0x0 and burstcount=16; exactly 16 wfifo_write pulses, data 0..15, each 1 cycle after its readdatavalid; second burst address=0x40.
- waitrequest held high for 10 cycles during REQ -> read, address and burstcount stable for all 10 cycles; exactly one acceptance; read=0 on the cycle after waitrequest falls.
- Run a full frame with HDISP=8, VDISP=4, BURSTSIZE=16 -> addresses 0x0, 0x40, then wrap to 0x0; 32 FIFO writes per frame.
- wfifo_almost_full=1 asserted during WAIT_DATA -> current burst completes with 16 writes; no new read until almost_full=0; then address continues at previous+0x40.
- frame_restart pulsed at beat 5 of the burst at 0x40 -> burst finishes all 16 beats; next request address=0x0.
- rst asserted at beat 7, then 9 stray readdatavalid beats arrive -> no wfifo_write during the stray beats; first post-reset request address=BASE_ADDR.
